huffman_cost_engine: RTL and testbench
======================================

Name: huffman_cost_engine

Overview:
- Parametrised successor to the current fixed 8-bit Huffman encoder top.
- Accepts a symbol stream for one message and builds a frequency histogram.
- Runs the Huffman merge sequence in hardware: repeated two-minimum search and combine.
- Reports the exact encoded payload size in bits. Sits in front of the code-assignment stage, which uses it to size output buffers.

Parameters:
- BIT_WIDTH, 4, symbol width; alphabet size ALPHA = 2**BIT_WIDTH.
- MAX_LEN, 255, maximum symbols per message; reaching it auto-closes the message.
- CNT_W, $clog2(MAX_LEN+1), histogram entry width. Merged weights never exceed MAX_LEN, so no wider storage is needed.
- TOT_W, 12, total-bit width; must hold MAX_LEN*(ALPHA-1).

Ports:
- clk_i  input  1  clock, all state on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- data_en_i  input  1  symbol valid; accepted when ready_o=1.
- input_text_i  input  BIT_WIDTH  symbol value.
- last_i  input  1  qualified by data_en_i; marks final symbol of message.
- ready_o  output  1  block can accept a symbol this cycle.
- done_o  output  1  total_bit_o valid for the just-closed message.
- trunc_o  output  1  message was closed by MAX_LEN rather than last_i.
- sym_count_o  output  CNT_W  symbols accepted in the closed message.
- total_bit_o  output  TOT_W  encoded size in bits.

Behaviour:
- Reset (async, rst_ni=0): histogram, accumulators and all outputs cleared. State IDLE, ready_o=1, done_o=0, trunc_o=0, sym_count_o=0, total_bit_o=0. Reset mid-MERGE aborts the message with no partial result.
- States: IDLE, COLLECT, MERGE, DONE. ready_o=1 in IDLE, COLLECT and DONE; ready_o=0 in MERGE.
- Acceptance in IDLE or DONE:
  - Starts a new message: hist[sym]=1 and count=1; every other hist entry is already 0.
  - In DONE, done_o and trunc_o drop on that edge. sym_count_o and total_bit_o hold until the next DONE.
- Acceptance in COLLECT: hist[sym]+=1, count+=1.
- Message close goes to MERGE. It occurs on an accepted symbol with last_i=1, or when count reaches MAX_LEN (that symbol is accepted and trunc_o is set at close). Symbols presented while ready_o=0 are dropped and not counted.
- IDLE/DONE with last_i on the first symbol: goes directly to MERGE.
- MERGE, one step per clock. Let D be the number of nonzero entries.
  - D>=2:
    - Find the smallest weight w1 at index i1 and the second smallest w2 at index i2; ties resolve to the lower index first.
    - acc += w1+w2; hist[i1]=w1+w2; hist[i2]=0.
  - D==1 on the first MERGE cycle (single distinct symbol): acc = count, a 1 bit/symbol convention.
  - D<=1 (end of merges): clear the remaining entry; total_bit_o=acc and sym_count_o=count are registered; go to DONE with done_o=1.
- Latency: done_o rises D clock edges after the edge that accepted the closing symbol, for D>=1. D-1 edges perform merges and one edge finalises.
- Two-minimum search is combinational over ALPHA entries within one cycle. acc is TOT_W wide; no saturation is required within parameter limits.
- done_o is a level, held in DONE until a new symbol is accepted or reset.

Test Plan:
- BIT_WIDTH=4; symbols 3,3,3,3 with last_i on the 4th → D=1, total_bit_o=4, sym_count_o=4, done_o 1 edge after close, trunc_o=0.
- Symbols 1,2 (last on 2) → total_bit_o=2, done_o 2 edges after close.
- Classic set: symbol 0 ×5, 1 ×9, 2 ×12, 3 ×13, 4 ×16, 5 ×45, interleaved, last on the 100th → total_bit_o=224, sym_count_o=100, done_o 6 edges after close.
- Ties: symbols 0,1,2,3 once each → total_bit_o=8. Check the merge order in hist: step 1 merges 0+1 into slot 0; step 2 merges 2+3 into slot 2; step 3 merges into slot 0.
- MAX_LEN=8 override: 10 symbols of value 7 with no last_i, then the bench holds data_en_i → 8 accepted, ready_o=0 in MERGE, symbols 9 and 10 dropped, trunc_o=1, total_bit_o=8.
- Reset and back-to-back:
  - Assert rst_ni=0 mid-MERGE → all outputs 0 immediately, state IDLE.
  - Then the message 5,5,6 → total_bit_o=3.
  - Then from DONE, the message 9 (last) → done_o drops for 1 cycle and returns with total_bit_o=1.

Source files
------------

// File: rtl/huffman_cost_engine.sv
// huffman_cost_engine: histograms one message and runs the Huffman merge sequence to size its encoded payload
module huffman_cost_engine #(
    parameter int BIT_WIDTH = 4,
    parameter int MAX_LEN   = 255,
    parameter int CNT_W     = $clog2(MAX_LEN + 1),
    parameter int TOT_W     = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 data_en_i,
    input  logic [BIT_WIDTH-1:0] input_text_i,
    input  logic                 last_i,
    output logic                 ready_o,
    output logic                 done_o,
    output logic                 trunc_o,
    output logic [CNT_W-1:0]     sym_count_o,
    output logic [TOT_W-1:0]     total_bit_o
);
    localparam int ALPHA = 2 ** BIT_WIDTH;
    typedef enum logic [1:0] {IDLE, COLLECT, MERGE, DONE} state_t;
    state_t               state;
    logic [CNT_W-1:0]     hist [ALPHA];
    logic [CNT_W-1:0]     count;
    logic [TOT_W-1:0]     acc;
    logic                 first;
    logic [CNT_W-1:0]     w1, w2, sum, next_count;
    logic [BIT_WIDTH-1:0] i1, i2;
    logic                 f1, f2, accept, start, hit_max, close;
    assign accept     = data_en_i & ready_o;
    assign start      = (state == IDLE) || (state == DONE);
    assign next_count = start ? CNT_W'(1) : count + CNT_W'(1);
    assign hit_max    = next_count == CNT_W'(MAX_LEN);
    assign close      = last_i | hit_max;
    assign sum        = w1 + w2;
    // two-minimum search over nonzero entries; ascending scan with strict compares puts tied lower indices first
    always_comb begin
        w1 = '0;
        w2 = '0;
        i1 = '0;
        i2 = '0;
        f1 = 1'b0;
        f2 = 1'b0;
        for (int j = 0; j < ALPHA; j++) begin
            if (hist[j] != '0) begin
                if (!f1 || hist[j] < w1) begin
                    w2 = w1;
                    i2 = i1;
                    f2 = f1;
                    w1 = hist[j];
                    i1 = BIT_WIDTH'(j);
                    f1 = 1'b1;
                end else if (!f2 || hist[j] < w2) begin
                    w2 = hist[j];
                    i2 = BIT_WIDTH'(j);
                    f2 = 1'b1;
                end
            end
        end
    end
    // control FSM: collect symbols, merge one pair per clock, finalise when one entry remains
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            for (int j = 0; j < ALPHA; j++) hist[j] <= '0;
            count       <= '0;
            acc         <= '0;
            first       <= 1'b0;
            ready_o     <= 1'b1;
            done_o      <= 1'b0;
            trunc_o     <= 1'b0;
            sym_count_o <= '0;
            total_bit_o <= '0;
        end else if (state == MERGE) begin
            first <= 1'b0;
            if (f2) begin
                acc      <= acc + TOT_W'(sum);
                hist[i1] <= sum;
                hist[i2] <= '0;
            end else begin
                for (int j = 0; j < ALPHA; j++) hist[j] <= '0;
                total_bit_o <= first ? TOT_W'(count) : acc;
                sym_count_o <= count;
                done_o      <= 1'b1;
                ready_o     <= 1'b1;
                state       <= DONE;
            end
        end else if (accept) begin
            hist[input_text_i] <= (start ? '0 : hist[input_text_i]) + CNT_W'(1);
            count   <= next_count;
            acc     <= start ? '0 : acc;
            done_o  <= 1'b0;
            trunc_o <= hit_max & ~last_i;
            first   <= 1'b1;
            ready_o <= ~close;
            state   <= close ? MERGE : COLLECT;
        end
    end
endmodule

// File: tb/tb_huffman_cost_engine.sv
// tb_huffman_cost_engine: directed checks of payload size, latency, tie order, truncation and reset
module tb_huffman_cost_engine;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        data_en_i = 1'b0;
    logic [3:0]  input_text_i = '0;
    logic        last_i = 1'b0;
    logic        ready_o, done_o, trunc_o;
    logic [7:0]  sym_count_o;
    logic [11:0] total_bit_o;
    logic        en8 = 1'b0;
    logic [3:0]  txt8 = '0;
    logic        last8 = 1'b0;
    logic        ready8, done8, trunc8;
    logic [3:0]  sc8;
    logic [11:0] tot8;
    int          n_assert = 0;
    int          n_fail = 0;

    huffman_cost_engine dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .data_en_i(data_en_i), .input_text_i(input_text_i),
        .last_i(last_i), .ready_o(ready_o), .done_o(done_o), .trunc_o(trunc_o),
        .sym_count_o(sym_count_o), .total_bit_o(total_bit_o)
    );

    huffman_cost_engine #(.MAX_LEN(8)) dut8 (
        .clk_i(clk_i), .rst_ni(rst_ni), .data_en_i(en8), .input_text_i(txt8),
        .last_i(last8), .ready_o(ready8), .done_o(done8), .trunc_o(trunc8),
        .sym_count_o(sc8), .total_bit_o(tot8)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] sym, input logic last);
        data_en_i = 1'b1;
        input_text_i = sym;
        last_i = last;
        @(posedge clk_i);
        #1;
        data_en_i = 1'b0;
        last_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_edges);
        int n = 0;
        while (done_o !== 1'b1 && n < 64) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        chk(tag, n, exp_edges);
    endtask

    initial begin
        int rem [6] = '{5, 9, 12, 13, 16, 45};
        int sent = 0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_ready", ready_o, 1);
        chk("rst_done", done_o, 0);
        chk("rst_trunc", trunc_o, 0);
        chk("rst_count", sym_count_o, 0);
        chk("rst_total", total_bit_o, 0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        send(3, 0); send(3, 0); send(3, 0); send(3, 1);
        chk("single_ready_merge", ready_o, 0);
        wait_done("single_latency", 1);
        chk("single_total", total_bit_o, 4);
        chk("single_count", sym_count_o, 4);
        chk("single_trunc", trunc_o, 0);
        chk("single_ready_done", ready_o, 1);

        send(1, 0); send(2, 1);
        chk("pair_done_drop", done_o, 0);
        wait_done("pair_latency", 2);
        chk("pair_total", total_bit_o, 2);
        chk("pair_count", sym_count_o, 2);

        while (sent < 100)
            for (int s = 0; s < 6; s++)
                if (rem[s] > 0) begin
                    rem[s]--;
                    sent++;
                    send(4'(s), sent == 100);
                end
        wait_done("classic_latency", 6);
        chk("classic_total", total_bit_o, 224);
        chk("classic_count", sym_count_o, 100);
        chk("classic_trunc", trunc_o, 0);

        send(0, 0); send(1, 0); send(2, 0); send(3, 1);
        @(posedge clk_i); #1;
        chk("tie1_slot0", dut.hist[0], 2);
        chk("tie1_slot1", dut.hist[1], 0);
        @(posedge clk_i); #1;
        chk("tie2_slot2", dut.hist[2], 2);
        chk("tie2_slot3", dut.hist[3], 0);
        @(posedge clk_i); #1;
        chk("tie3_slot0", dut.hist[0], 4);
        chk("tie3_slot2", dut.hist[2], 0);
        wait_done("tie_final_latency", 1);
        chk("tie_total", total_bit_o, 8);

        en8 = 1'b1;
        txt8 = 4'd7;
        repeat (8) @(posedge clk_i);
        #1;
        chk("max_ready_merge", ready8, 0);
        chk("max_trunc_close", trunc8, 1);
        chk("max_done_merge", done8, 0);
        @(posedge clk_i);
        #1;
        en8 = 1'b0;
        chk("max_done", done8, 1);
        chk("max_count", sc8, 8);
        chk("max_total", tot8, 8);
        chk("max_trunc", trunc8, 1);

        send(0, 0); send(1, 0); send(2, 0); send(3, 1);
        @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("amid_total", total_bit_o, 0);
        chk("amid_count", sym_count_o, 0);
        chk("amid_done", done_o, 0);
        chk("amid_ready", ready_o, 1);
        chk("amid_state", dut.state, 0);
        chk("amid_hist0", dut.hist[0], 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        send(5, 0); send(5, 0); send(6, 1);
        wait_done("b2b_latency", 2);
        chk("b2b_total", total_bit_o, 3);
        chk("b2b_count", sym_count_o, 3);
        send(9, 1);
        chk("b2b_done_drop", done_o, 0);
        chk("b2b_total_hold", total_bit_o, 3);
        wait_done("b2b2_latency", 1);
        chk("b2b2_total", total_bit_o, 1);
        chk("b2b2_count", sym_count_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
